// File: rtl/clock_pkg.sv
// Shared types and limits for the HH:MM time-setting controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HRS  = 2'd1,
    SET_MINS = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  localparam int HRS_W  = 5;
  localparam int MINS_W = 6;

  localparam logic [HRS_W-1:0]  MAX_HRS  = 5'd23;
  localparam logic [MINS_W-1:0] MAX_MINS = 6'd59;

  // Out-of-range live values (e.g. before the datapath settles) start editing at 0.
  function automatic logic [HRS_W-1:0] clamp_hrs(input logic [HRS_W-1:0] h);
    return (h > MAX_HRS) ? '0 : h;
  endfunction

  function automatic logic [MINS_W-1:0] clamp_mins(input logic [MINS_W-1:0] m);
    return (m > MAX_MINS) ? '0 : m;
  endfunction

  function automatic logic [HRS_W-1:0] wrap_inc_hrs(input logic [HRS_W-1:0] h);
    return (h == MAX_HRS) ? '0 : h + 1'b1;
  endfunction

  function automatic logic [MINS_W-1:0] wrap_inc_mins(input logic [MINS_W-1:0] m);
    return (m == MAX_MINS) ? '0 : m + 1'b1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button to single-cycle press pulse: 2-FF sync, stability counter, rising-edge detect.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      // Any cycle where the synced level agrees with the accepted level restarts the count.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode controller: pauses timekeeping while hours/minutes are edited, then loads them.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES    = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [HRS_W-1:0]  cur_hrs,
  input  logic [MINS_W-1:0] cur_mins,
  output logic              run_en,
  output logic              load,
  output logic [HRS_W-1:0]  load_hrs,
  output logic [MINS_W-1:0] load_mins,
  output logic              blank_hrs,
  output logic              blank_mins,
  output logic [1:0]        mode
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic mode_p, inc_p;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_mode),
    .press (mode_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_inc),
    .press (inc_p)
  );

  state_t            state;
  logic [HRS_W-1:0]  edit_hrs;
  logic [MINS_W-1:0] edit_mins;
  logic [BW-1:0]     blink_cnt;
  logic              phase;
  logic              editing;

  assign editing = (state == SET_HRS) || (state == SET_MINS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      run_en    <= 1'b1;
      load      <= 1'b0;
      edit_hrs  <= '0;
      edit_mins <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      load <= 1'b0;
      // mode is checked first everywhere so a coincident inc is dropped.
      case (state)
        RUN: begin
          if (mode_p) begin
            state     <= SET_HRS;
            run_en    <= 1'b0;
            edit_hrs  <= clamp_hrs(cur_hrs);
            edit_mins <= clamp_mins(cur_mins);
          end
        end
        SET_HRS: begin
          if (mode_p)     state    <= SET_MINS;
          else if (inc_p) edit_hrs <= wrap_inc_hrs(edit_hrs);
        end
        SET_MINS: begin
          if (mode_p) begin
            state <= COMMIT;
            load  <= 1'b1;
          end else if (inc_p) begin
            edit_mins <= wrap_inc_mins(edit_mins);
          end
        end
        COMMIT: begin
          state  <= RUN;
          run_en <= 1'b1;
        end
        default: begin
          state  <= RUN;
          run_en <= 1'b1;
        end
      endcase

      // Any press restarts the blink visible-first, so a new field or value shows at once.
      if (editing && !mode_p && !inc_p) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end
    end
  end

  assign load_hrs   = edit_hrs;
  assign load_mins  = edit_mins;
  assign mode       = state;
  assign blank_hrs  = (state == SET_HRS)  && phase;
  assign blank_mins = (state == SET_MINS) && phase;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl with short debounce/blink periods.
module tb_clock_set_ctrl;

  localparam int DB = 4;
  localparam int BL = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hrs = 5'd12;
  logic [5:0] cur_mins = 6'd34;
  logic       run_en, load, blank_hrs, blank_mins;
  logic [4:0] load_hrs;
  logic [5:0] load_mins;
  logic [1:0] mode;

  clock_set_ctrl #(.DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .cur_hrs    (cur_hrs),
    .cur_mins   (cur_mins),
    .run_en     (run_en),
    .load       (load),
    .load_hrs   (load_hrs),
    .load_mins  (load_mins),
    .blank_hrs  (blank_hrs),
    .blank_mins (blank_mins),
    .mode       (mode)
  );

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic       run_en;
    logic       load;
    logic [4:0] hrs;
    logic [5:0] mins;
  } exp_t;

  typedef struct {
    int   cyc;
    logic bh;
    logic bm;
  } blink_t;

  exp_t   q[$];
  blink_t bq[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     cyc = 0;
  bit     blink_chk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // c < 0 means the change may occur on any cycle.
  task automatic expect_out(input int c, input int m, input int r, input int l,
                            input int h, input int mi);
    exp_t e;
    e.cyc = c; e.mode = 2'(m); e.run_en = 1'(r); e.load = 1'(l);
    e.hrs = 5'(h); e.mins = 6'(mi);
    q.push_back(e);
  endtask

  task automatic expect_blink(input int c, input int bh, input int bm);
    blink_t b;
    b.cyc = c; b.bh = 1'(bh); b.bm = 1'(bm);
    bq.push_back(b);
  endtask

  // Called on a negedge; leaves the buttons released and debounced low.
  task automatic press(input bit m, input bit i, input int hold);
    btn_mode = m;
    btn_inc  = i;
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Output monitor: every change of the non-blink outputs pops one expectation.
  logic [14:0] prev_obs;
  bit          first = 1'b1;
  always @(negedge clk) begin : mon_out
    logic [14:0] obs;
    exp_t        e;
    obs = {mode, run_en, load, load_hrs, load_mins};
    if (first || obs !== prev_obs) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got mode=%0d run=%b load=%b hrs=%0d mins=%0d at cyc %0d, want no change",
                 mode, run_en, load, load_hrs, load_mins, cyc);
      end else begin
        e = q.pop_front();
        if (mode !== e.mode || run_en !== e.run_en || load !== e.load ||
            load_hrs !== e.hrs || load_mins !== e.mins ||
            blank_hrs !== 1'b0 || blank_mins !== 1'b0 ||
            (e.cyc >= 0 && e.cyc != cyc)) begin
          n_fail++;
          $display("FAIL out_seq: got mode=%0d run=%b load=%b hrs=%0d mins=%0d bh=%b bm=%b cyc=%0d, want mode=%0d run=%b load=%b hrs=%0d mins=%0d bh=0 bm=0 cyc=%0d",
                   mode, run_en, load, load_hrs, load_mins, blank_hrs, blank_mins, cyc,
                   e.mode, e.run_en, e.load, e.hrs, e.mins, e.cyc);
        end
      end
    end
    prev_obs = obs;
    first    = 1'b0;
  end

  // Blink monitor: active only inside the idle window, times each blank transition.
  logic [1:0] prev_blank = 2'b00;
  always @(negedge clk) begin : mon_blink
    logic [1:0] bcur;
    blink_t     b;
    bcur = {blank_hrs, blank_mins};
    if (blink_chk && bcur !== prev_blank) begin
      n_chk++;
      if (bq.size() == 0) begin
        n_fail++;
        $display("FAIL blink_unexpected: got bh=%b bm=%b at cyc %0d, want no change",
                 blank_hrs, blank_mins, cyc);
      end else begin
        b = bq.pop_front();
        if (blank_hrs !== b.bh || blank_mins !== b.bm || cyc != b.cyc) begin
          n_fail++;
          $display("FAIL blink_seq: got bh=%b bm=%b cyc=%0d, want bh=%b bm=%b cyc=%0d",
                   blank_hrs, blank_mins, cyc, b.bh, b.bm, b.cyc);
        end
      end
    end
    prev_blank = bcur;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of stimulus, want finish within budget");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    expect_out(-1, 0, 1, 0, 0, 0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Enter SET_HRS: state visible 7 edges after the raw edge (press pulse at 6).
    expect_out(cyc + 7, 1, 0, 0, 12, 34);
    press(1'b1, 1'b0, 10);

    // 3-cycle glitch is filtered, then a real inc.
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    expect_out(cyc + 7, 1, 0, 0, 13, 34);
    press(1'b0, 1'b1, 10);

    // Hours up to 23 and wrap to 0.
    for (int h = 14; h <= 23; h++) begin
      expect_out(-1, 1, 0, 0, h, 34);
      press(1'b0, 1'b1, 10);
    end
    expect_out(-1, 1, 0, 0, 0, 34);
    press(1'b0, 1'b1, 10);

    // Minutes up to 59 and wrap to 0, hours untouched.
    expect_out(-1, 2, 0, 0, 0, 34);
    press(1'b1, 1'b0, 10);
    for (int m = 35; m <= 59; m++) begin
      expect_out(-1, 2, 0, 0, 0, m);
      press(1'b0, 1'b1, 10);
    end
    expect_out(-1, 2, 0, 0, 0, 0);
    press(1'b0, 1'b1, 10);

    // Commit: exactly one load cycle.
    k = cyc;
    expect_out(k + 7, 3, 0, 1, 0, 0);
    expect_out(k + 8, 0, 1, 0, 0, 0);
    press(1'b1, 1'b0, 10);

    // Full sequence from 12:34 to 14:35.
    expect_out(-1, 1, 0, 0, 12, 34); press(1'b1, 1'b0, 10);
    expect_out(-1, 1, 0, 0, 13, 34); press(1'b0, 1'b1, 10);
    expect_out(-1, 1, 0, 0, 14, 34); press(1'b0, 1'b1, 10);
    expect_out(-1, 2, 0, 0, 14, 34); press(1'b1, 1'b0, 10);
    expect_out(-1, 2, 0, 0, 14, 35); press(1'b0, 1'b1, 10);
    k = cyc;
    expect_out(k + 7, 3, 0, 1, 14, 35);
    expect_out(k + 8, 0, 1, 0, 14, 35);
    press(1'b1, 1'b0, 10);

    // Out-of-range live time is captured as 00:00.
    cur_hrs  = 5'd25;
    cur_mins = 6'd61;
    expect_out(-1, 1, 0, 0, 0, 0); press(1'b1, 1'b0, 10);
    expect_out(-1, 1, 0, 0, 1, 0); press(1'b0, 1'b1, 10);

    // Coincident mode+inc: mode wins, hours stay 1; then idle in SET_MINS.
    k = cyc;
    expect_out(k + 7, 2, 0, 0, 1, 0);
    expect_blink(k + 15, 0, 1);
    expect_blink(k + 23, 0, 0);
    expect_blink(k + 31, 0, 1);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    repeat (9) @(negedge clk);
    blink_chk = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (25) @(negedge clk);
    blink_chk = 1'b0;
    n_chk++;
    if (bq.size() != 0) begin
      n_fail++;
      $display("FAIL blink_drain: got %0d pending blink transitions, want 0", bq.size());
    end

    // Reset mid-edit: straight back to RUN values with no load pulse.
    expect_out(-1, 0, 1, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL out_drain: got %0d pending output changes, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-setting controller for the 24-hour HH:MM clock datapath. It debounces two push-buttons, mode and inc, and runs a set-mode state machine. While the user edits, it pauses timekeeping, holds the edit fields, and drives load strobes plus digit-blink enables. It sits between the board buttons and the hours/minutes counters and the 7-segment display mux.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz).
BLINK_CYCLES, 25_000_000, half-period of the edit-digit blink in clk cycles (2 Hz blink at 100 MHz).

Ports:
clk  input  1  system clock, single domain
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
btn_mode  input  1  raw mode button, asynchronous, active-high
btn_inc  input  1  raw increment button, asynchronous, active-high
cur_hrs  input  5  live hours from the datapath, 0..23
cur_mins  input  6  live minutes from the datapath, 0..59
run_en  output  1  1 = timekeeping counters may advance
load  output  1  one-cycle strobe; datapath loads load_hrs/load_mins and clears its seconds prescaler
load_hrs  output  5  hours value to load
load_mins  output  6  minutes value to load
blank_hrs  output  1  1 = display blanks both hour digits
blank_mins  output  1  1 = display blanks both minute digits
mode  output  2  current state encoding, for debug LEDs

Behaviour:
- Reset values (asserted or released): state RUN, run_en=1, load=0, load_hrs=0, load_mins=0, blank_hrs=0, blank_mins=0, mode=0, edit fields 0, blink counter 0, blink phase 0, debouncers at debounced=0 with counter 0.
- Button path, per button:
  - 2-FF synchronizer.
  - Debounce counter: counts while the synchronized level differs from the debounced level. It resets to 0 on any cycle where the levels match.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level updates on the next edge.
  - A debounced 0->1 transition produces a single-cycle press pulse.
  - Latency from a stable raw edge to the press pulse is 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
  - A held button produces exactly one pulse; there is no auto-repeat.
- State machine (mode encoding in brackets):
  - RUN [0]:
    - run_en=1; inc press ignored.
    - mode press: edit_hrs <= cur_hrs, or 0 if cur_hrs>23; edit_mins <= cur_mins, or 0 if cur_mins>59. Go to SET_HRS.
  - SET_HRS [1]:
    - run_en=0.
    - inc press: edit_hrs <= (edit_hrs==23) ? 0 : edit_hrs+1.
    - mode press: go to SET_MINS.
  - SET_MINS [2]:
    - run_en=0.
    - inc press: edit_mins <= (edit_mins==59) ? 0 : edit_mins+1.
    - mode press: go to COMMIT.
  - COMMIT [3]:
    - Lasts exactly one cycle; load=1, run_en=0.
    - load_hrs=edit_hrs, load_mins=edit_mins.
    - Unconditionally go to RUN.
- Outputs are registered; load asserts on the cycle the state register holds COMMIT.
- load_hrs/load_mins continuously reflect the edit fields in every state.
- Simultaneous mode and inc press in the same cycle: mode wins; inc is discarded, with no increment of the field being left.
- Presses arriving during COMMIT are discarded.
- Blink:
  - The blink counter runs only in SET_HRS/SET_MINS. It toggles blink phase every BLINK_CYCLES cycles.
  - The counter and phase clear to 0 on every state change, so a newly selected field is visible first.
  - An inc press also clears the counter and phase, so the new value shows immediately.
  - blank_hrs = (state==SET_HRS) & phase; blank_mins = (state==SET_MINS) & phase.
  - Both blanks are 0 in RUN and COMMIT.
- Reset mid-edit: edit is abandoned, no load pulse, state RUN.

Decomposition:
- Shared package clock_pkg holds:
  - state enum: RUN=0, SET_HRS=1, SET_MINS=2, COMMIT=3
  - MAX_HRS=23, MAX_MINS=59
  - HRS_W=5, MINS_W=6
- One sub-module, button_debounce: synchronizer, debounce counter and rising-edge pulse, parameterized by DEBOUNCE_CYCLES. It is instantiated twice.
- The FSM, edit registers and blink logic stay in clock_set_ctrl.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and BLINK_CYCLES=8.
1. Reset released, cur_hrs=12, cur_mins=34, mode pressed for 10 cycles -> one press pulse 6 cycles after the raw edge; mode=1, run_en=0, load_hrs=12, load_mins=34.
2. btn_inc high for 3 cycles then low, while in SET_HRS -> no press, edit_hrs stays 12; an inc pulse of 10 cycles -> edit_hrs=13.
3. SET_HRS with edit_hrs=23, inc press -> 0. SET_MINS with edit_mins=59, inc press -> 0; edit_hrs unchanged.
4. Full sequence mode, inc x2, mode, inc, mode from 12:34 -> exactly one load=1 cycle with load_hrs=14, load_mins=35; then mode=0, run_en=1.
5. Debounced mode and inc pulses in the same cycle while in SET_HRS -> state SET_MINS, edit_hrs unchanged.
6. Idle 20 cycles in SET_MINS -> blank_mins toggles every 8 cycles starting low, blank_hrs=0. Reset asserted mid-edit -> all outputs at reset values, load never pulses.
